row_pack_mdl: RTL

Upstream stage of the matrix row buffer. Accepts a stream of ELEM_W-bit matrix elements and packs ELEMS_PER_ROW of them into one ROW_W-bit row word. Presents each row with a one-cycle valid strobe on the buffer's row-data/enable inputs, and pulses the end-of-matrix flag after the last row. Enforces a per-matrix row limit and flags overflow.

---
 rtl/rowpack_pkg.sv | 17 +
 rtl/row_pack_mdl.sv | 107 ++++++++++
 2 files changed

// File: rtl/rowpack_pkg.sv
// Shared widths, defaults and FSM state type for the matrix row packer.
package rowpack_pkg;

   localparam int unsigned ELEM_W        = 16;
   localparam int unsigned ELEMS_PER_ROW = 64;
   localparam int unsigned ROW_W         = ELEM_W * ELEMS_PER_ROW;
   localparam int unsigned MAX_ROWS      = 8;
   localparam int unsigned IDX_W         = $clog2(ELEMS_PER_ROW);
   localparam int unsigned CNT_W         = 4;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      EMIT = 2'd1,
      END  = 2'd2
   } state_t;

endpackage

// File: rtl/row_pack_mdl.sv
// Packs ELEM_W-bit elements LSB-first into ROW_W-bit rows, strobes each row and flags end of matrix.
// Optional ROWPACK_PARITY_EN adds a row_parity output (XOR reduction of each emitted row).
module row_pack_mdl
   import rowpack_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [ELEM_W-1:0] elem_in,
   input  logic              elem_valid,
   input  logic              elem_last,
   output logic              elem_ready,
   output logic [ROW_W-1:0]  dats,
   output logic              dats_valid,
   output logic              dend_flag,
   output logic [CNT_W-1:0]  row_count,
   output logic              ovf_err
`ifdef ROWPACK_PARITY_EN
   ,
   output logic              row_parity
`endif
);

   state_t             state_q;
   state_t             state_d;
   logic [IDX_W-1:0]   idx_q;
   logic [ROW_W-1:0]   row_q;
   logic [ROW_W-1:0]   row_merged;
   logic               last_q;
   logic               accept;
   logic               full;
   logic               store;
   logic               drop;
   logic               row_done;

   // Handshake qualification and next-state selection.
   always_comb begin
      accept     = elem_valid & elem_ready;
      full       = (row_count == CNT_W'(MAX_ROWS));
      store      = accept & ~full;
      drop       = accept & full;
      row_done   = store & (elem_last | (idx_q == IDX_W'(ELEMS_PER_ROW - 1)));
      row_merged = row_q;
      row_merged[32'(idx_q) * ELEM_W +: ELEM_W] = elem_in;
      state_d    = state_q;
      case (state_q)
         FILL: begin
            if (row_done)
               state_d = EMIT;
            else if (drop & elem_last)
               state_d = END;
         end
         EMIT:    state_d = last_q ? END : FILL;
         END:     state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state_q <= FILL;
      else
         state_q <= state_d;
   end

   // Datapath and registered outputs; the shadow row is cleared as it is handed to dats.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx_q      <= '0;
         row_q      <= '0;
         last_q     <= 1'b0;
         elem_ready <= 1'b0;
         dats       <= '0;
         dats_valid <= 1'b0;
         dend_flag  <= 1'b0;
         row_count  <= '0;
         ovf_err    <= 1'b0;
`ifdef ROWPACK_PARITY_EN
         row_parity <= 1'b0;
`endif
      end else begin
         elem_ready <= (state_d == FILL);
         dats_valid <= (state_d == EMIT);
         dend_flag  <= (state_d == END);
         if (row_done) begin
            dats      <= row_merged;
            row_q     <= '0;
            idx_q     <= '0;
            last_q    <= elem_last;
            row_count <= row_count + CNT_W'(1);
`ifdef ROWPACK_PARITY_EN
            row_parity <= ^row_merged;
`endif
         end else if (store) begin
            row_q[32'(idx_q) * ELEM_W +: ELEM_W] <= elem_in;
            idx_q <= idx_q + IDX_W'(1);
         end
         if (drop)
            ovf_err <= 1'b1;
         if (state_q == END) begin
            row_count <= '0;
            ovf_err   <= 1'b0;
            last_q    <= 1'b0;
         end
      end
   end

endmodule
